// File: rtl/rv32_fetch_pkg.sv
// Shared constants and state encoding for the RV32 instruction fetch stage.
package rv32_fetch_pkg;

    // Canonical NOP: addi x0, x0, 0
    localparam logic [31:0] RV32_NOP = 32'h0000_0013;

    // Fetch controller states
    typedef enum logic [2:0] {
        FS_IDLE  = 3'd0,
        FS_REQ   = 3'd1,
        FS_WAIT  = 3'd2,
        FS_HOLD  = 3'd3,
        FS_FAULT = 3'd4
    } fetch_state_e;

endpackage

// File: rtl/rv32_fetch_ctrl.sv
// Fetch controller: sequences one outstanding instruction-memory request at a
// time, tracks responses that must be dropped after a redirect, and emits the
// capture strobe used by the top level to load IR/pc_o and advance the PC.
module rv32_fetch_ctrl
    import rv32_fetch_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic imem_gnt_i,
    input  logic imem_rvalid_i,
    input  logic redirect_i,
    input  logic misalign_i,
    input  logic slot_free_i,
    output logic imem_req_o,
    output logic capture_o
);

    fetch_state_e state_q, state_d;
    logic         discard_q, discard_d;
    logic         pending;

    // A response is still on its way after this cycle: the request was just
    // granted, or we were already waiting for one and it has not arrived yet.
    assign pending = (state_q == FS_REQ && imem_gnt_i) ||
                     ((state_q == FS_WAIT || discard_q) && !imem_rvalid_i);

    // State and discard-flag registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= FS_IDLE;
            discard_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            discard_q <= discard_d;
        end
    end

    // Next-state logic; redirect overrides every normal transition
    always_comb begin
        state_d    = state_q;
        discard_d  = discard_q;
        imem_req_o = 1'b0;
        capture_o  = 1'b0;

        case (state_q)
            FS_IDLE: state_d = slot_free_i ? FS_REQ : FS_HOLD;
            FS_REQ: begin
                imem_req_o = 1'b1;
                if (imem_gnt_i) state_d = FS_WAIT;
            end
            FS_WAIT: begin
                if (imem_rvalid_i) begin
                    if (discard_q) begin
                        discard_d = 1'b0;
                        state_d   = FS_REQ;
                    end else begin
                        capture_o = 1'b1;
                        state_d   = FS_HOLD;
                    end
                end
            end
            FS_HOLD: begin
                if (slot_free_i) state_d = FS_REQ;
            end
            FS_FAULT: begin
                // Slot is pinned; only a stale response may still need draining.
                if (imem_rvalid_i) discard_d = 1'b0;
            end
            default: state_d = FS_IDLE;
        endcase

        if (redirect_i) begin
            capture_o = 1'b0;
            discard_d = pending;
            if (misalign_i) state_d = FS_FAULT;
            else            state_d = pending ? FS_WAIT : FS_REQ;
        end
    end

endmodule

// File: rtl/rv32_fetch_unit.sv
// RV32 instruction fetch stage: fetch PC, IR and pc_o registers plus the +4
// adder, around the rv32_fetch_ctrl sequencer.
// Optional feature macro: RV32_FETCH_MISALIGN_EN (misaligned redirect targets
// raise fetch_fault instead of being silently word-aligned).
module rv32_fetch_unit
    import rv32_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        ir_valid,
    output logic [31:0] IR,
    output logic [31:0] pc_o,
    output logic        fetch_fault
);

    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] pc_q, pc_d;
    logic        ir_valid_q, ir_valid_d;
    logic        fault_q, fault_d;
    logic [31:0] redirect_tgt;
    logic        misalign;
    logic        slot_free;
    logic        consume;
    logic        capture;

`ifdef RV32_FETCH_MISALIGN_EN
    assign redirect_tgt = redirect_pc;
    assign misalign     = redirect_valid && (redirect_pc[1:0] != 2'b00);
`else
    assign redirect_tgt = redirect_pc & ~32'h0000_0003;
    assign misalign     = 1'b0;
`endif

    assign consume   = ir_valid_q && !stall;
    assign slot_free = !ir_valid_q || !stall;

    rv32_fetch_ctrl u_ctrl (
        .clk           (clk),
        .rst           (rst),
        .imem_gnt_i    (imem_gnt),
        .imem_rvalid_i (imem_rvalid),
        .redirect_i    (redirect_valid),
        .misalign_i    (misalign),
        .slot_free_i   (slot_free),
        .imem_req_o    (imem_req),
        .capture_o     (capture)
    );

    // Next values for PC/IR slot: redirect, then capture, then consume
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        ir_d       = ir_q;
        pc_d       = pc_q;
        ir_valid_d = ir_valid_q;
        fault_d    = fault_q;
        if (redirect_valid) begin
            fetch_pc_d = redirect_tgt;
            ir_valid_d = misalign;
            fault_d    = misalign;
            if (misalign) begin
                ir_d = RV32_NOP;
                pc_d = redirect_pc;
            end
        end else if (capture) begin
            ir_d       = imem_rdata;
            pc_d       = fetch_pc_q;
            ir_valid_d = 1'b1;
            fetch_pc_d = fetch_pc_q + 32'd4;
        end else if (consume && !fault_q) begin
            ir_valid_d = 1'b0;
        end
    end

    // PC and IR slot registers
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            ir_q       <= RV32_NOP;
            pc_q       <= RESET_PC;
            ir_valid_q <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            ir_q       <= ir_d;
            pc_q       <= pc_d;
            ir_valid_q <= ir_valid_d;
            fault_q    <= fault_d;
        end
    end

    assign imem_addr   = fetch_pc_q;
    assign ir_valid    = ir_valid_q;
    assign IR          = ir_q;
    assign pc_o        = pc_q;
    assign fetch_fault = fault_q;

endmodule

// File: tb/tb_rv32_fetch_unit.sv
// Directed bench for rv32_fetch_unit: a per-cycle vector table driving the
// memory/stall/redirect inputs and checking the registered outputs, followed
// by a hand-written misaligned-redirect sequence.
module tb_rv32_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        ir_valid;
    logic [31:0] IR;
    logic [31:0] pc_o;
    logic        fetch_fault;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    rv32_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .ir_valid       (ir_valid),
        .IR             (IR),
        .pc_o           (pc_o),
        .fetch_fault    (fetch_fault)
    );

    typedef struct {
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
        logic        stall;
        logic        redir;
        logic [31:0] rpc;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_irv;
        logic [31:0] e_ir;
        logic [31:0] e_pc;
    } vec_t;

    vec_t vt[$];

    task automatic add(input logic g, input logic rv, input logic [31:0] rd,
                       input logic st, input logic re, input logic [31:0] rp,
                       input logic eq, input logic [31:0] ea, input logic ev,
                       input logic [31:0] ei, input logic [31:0] ep);
        vec_t v;
        v.gnt = g; v.rvalid = rv; v.rdata = rd; v.stall = st; v.redir = re; v.rpc = rp;
        v.e_req = eq; v.e_addr = ea; v.e_irv = ev; v.e_ir = ei; v.e_pc = ep;
        vt.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic g, input logic rv, input logic [31:0] rd,
                         input logic st, input logic re, input logic [31:0] rp);
        imem_gnt = g; imem_rvalid = rv; imem_rdata = rd;
        stall = st; redirect_valid = re; redirect_pc = rp;
    endtask

    initial begin
        drive(0, 0, 32'h0, 0, 0, 32'h0);
        rst = 1'b1;

        //      gnt rv rdata         st re rpc            req addr           irv IR            pc
        add(0, 0, 32'h0,         0, 0, 32'h0,         0, 32'h0000_0000, 0, 32'h0000_0013, 32'h0000_0000); // 0 IDLE
        add(1, 0, 32'h0,         0, 0, 32'h0,         1, 32'h0000_0000, 0, 32'h0000_0013, 32'h0000_0000); // 1 REQ gnt
        add(0, 1, 32'h0050_0093, 0, 0, 32'h0,         0, 32'h0000_0000, 0, 32'h0000_0013, 32'h0000_0000); // 2 WAIT rvalid
        add(0, 0, 32'h0,         1, 0, 32'h0,         0, 32'h0000_0004, 1, 32'h0050_0093, 32'h0000_0000); // 3 stall
        add(0, 0, 32'h0,         1, 0, 32'h0,         0, 32'h0000_0004, 1, 32'h0050_0093, 32'h0000_0000);
        add(0, 0, 32'h0,         1, 0, 32'h0,         0, 32'h0000_0004, 1, 32'h0050_0093, 32'h0000_0000);
        add(0, 0, 32'h0,         1, 0, 32'h0,         0, 32'h0000_0004, 1, 32'h0050_0093, 32'h0000_0000);
        add(0, 0, 32'h0,         1, 0, 32'h0,         0, 32'h0000_0004, 1, 32'h0050_0093, 32'h0000_0000); // 7
        add(0, 0, 32'h0,         0, 0, 32'h0,         0, 32'h0000_0004, 1, 32'h0050_0093, 32'h0000_0000); // 8 consume
        add(0, 0, 32'h0,         0, 0, 32'h0,         1, 32'h0000_0004, 0, 32'h0050_0093, 32'h0000_0000); // 9 REQ no gnt
        add(1, 0, 32'h0,         0, 0, 32'h0,         1, 32'h0000_0004, 0, 32'h0050_0093, 32'h0000_0000); // 10 gnt
        add(0, 0, 32'h0,         0, 0, 32'h0,         0, 32'h0000_0004, 0, 32'h0050_0093, 32'h0000_0000); // 11 late rvalid
        add(0, 1, 32'h00A0_0113, 0, 0, 32'h0,         0, 32'h0000_0004, 0, 32'h0050_0093, 32'h0000_0000); // 12
        add(0, 0, 32'h0,         0, 0, 32'h0,         0, 32'h0000_0008, 1, 32'h00A0_0113, 32'h0000_0004); // 13 consume
        add(1, 0, 32'h0,         0, 0, 32'h0,         1, 32'h0000_0008, 0, 32'h00A0_0113, 32'h0000_0004); // 14 gnt
        add(0, 0, 32'h0,         0, 1, 32'h0000_0100, 0, 32'h0000_0008, 0, 32'h00A0_0113, 32'h0000_0004); // 15 redirect in WAIT
        add(0, 0, 32'h0,         0, 0, 32'h0,         0, 32'h0000_0100, 0, 32'h00A0_0113, 32'h0000_0004); // 16
        add(0, 1, 32'hDEAD_BEEF, 0, 0, 32'h0,         0, 32'h0000_0100, 0, 32'h00A0_0113, 32'h0000_0004); // 17 stale dropped
        add(1, 0, 32'h0,         0, 0, 32'h0,         1, 32'h0000_0100, 0, 32'h00A0_0113, 32'h0000_0004); // 18
        add(0, 1, 32'h1234_5678, 0, 1, 32'h0000_0200, 0, 32'h0000_0100, 0, 32'h00A0_0113, 32'h0000_0004); // 19 redirect+rvalid
        add(0, 0, 32'h0,         0, 1, 32'h0000_0300, 1, 32'h0000_0200, 0, 32'h00A0_0113, 32'h0000_0004); // 20 redirect in REQ
        add(1, 0, 32'h0,         0, 0, 32'h0,         1, 32'h0000_0300, 0, 32'h00A0_0113, 32'h0000_0004); // 21
        add(0, 1, 32'h0000_0513, 0, 0, 32'h0,         0, 32'h0000_0300, 0, 32'h00A0_0113, 32'h0000_0004); // 22
        add(0, 0, 32'h0,         1, 1, 32'hFFFF_FFFC, 0, 32'h0000_0304, 1, 32'h0000_0513, 32'h0000_0300); // 23 redirect in stall
        add(1, 0, 32'h0,         1, 0, 32'h0,         1, 32'hFFFF_FFFC, 0, 32'h0000_0513, 32'h0000_0300); // 24
        add(0, 1, 32'h0000_006F, 0, 0, 32'h0,         0, 32'hFFFF_FFFC, 0, 32'h0000_0513, 32'h0000_0300); // 25
        add(0, 0, 32'h0,         0, 0, 32'h0,         0, 32'h0000_0000, 1, 32'h0000_006F, 32'hFFFF_FFFC); // 26 wrap
        add(1, 0, 32'h0,         0, 0, 32'h0,         1, 32'h0000_0000, 0, 32'h0000_006F, 32'hFFFF_FFFC); // 27
        add(0, 1, 32'h0010_0073, 0, 0, 32'h0,         0, 32'h0000_0000, 0, 32'h0000_006F, 32'hFFFF_FFFC); // 28
        add(0, 0, 32'h0,         0, 0, 32'h0,         0, 32'h0000_0004, 1, 32'h0010_0073, 32'h0000_0000); // 29
        add(1, 0, 32'h0,         0, 1, 32'h0000_0040, 1, 32'h0000_0004, 0, 32'h0010_0073, 32'h0000_0000); // 30 redirect+gnt
        add(0, 0, 32'h0,         0, 1, 32'h0000_0080, 0, 32'h0000_0040, 0, 32'h0010_0073, 32'h0000_0000); // 31 back-to-back
        add(0, 1, 32'hBAD0_BAD0, 0, 0, 32'h0,         0, 32'h0000_0080, 0, 32'h0010_0073, 32'h0000_0000); // 32 dropped
        add(1, 0, 32'h0,         0, 0, 32'h0,         1, 32'h0000_0080, 0, 32'h0010_0073, 32'h0000_0000); // 33
        add(0, 1, 32'h0000_0093, 0, 0, 32'h0,         0, 32'h0000_0080, 0, 32'h0010_0073, 32'h0000_0000); // 34
        add(0, 0, 32'h0,         0, 0, 32'h0,         0, 32'h0000_0084, 1, 32'h0000_0093, 32'h0000_0080); // 35
        add(0, 0, 32'h0,         0, 0, 32'h0,         1, 32'h0000_0084, 0, 32'h0000_0093, 32'h0000_0080); // 36 REQ

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_req",   {31'h0, imem_req},    32'h0);
        check("rst_addr",  imem_addr,            32'h0);
        check("rst_irv",   {31'h0, ir_valid},    32'h0);
        check("rst_ir",    IR,                   32'h0000_0013);
        check("rst_pc",    pc_o,                 32'h0);
        check("rst_fault", {31'h0, fetch_fault}, 32'h0);
        rst = 1'b0;

        for (int i = 0; i < vt.size(); i++) begin
            check($sformatf("v%0d_req", i),   {31'h0, imem_req},    {31'h0, vt[i].e_req});
            check($sformatf("v%0d_addr", i),  imem_addr,            vt[i].e_addr);
            check($sformatf("v%0d_irv", i),   {31'h0, ir_valid},    {31'h0, vt[i].e_irv});
            check($sformatf("v%0d_ir", i),    IR,                   vt[i].e_ir);
            check($sformatf("v%0d_pc", i),    pc_o,                 vt[i].e_pc);
            check($sformatf("v%0d_fault", i), {31'h0, fetch_fault}, 32'h0);
            drive(vt[i].gnt, vt[i].rvalid, vt[i].rdata, vt[i].stall, vt[i].redir, vt[i].rpc);
            @(negedge clk);
        end

        // Misaligned redirect from REQ (no grant outstanding)
        drive(0, 0, 32'h0, 0, 1, 32'h0000_0102);
        @(negedge clk);
`ifdef RV32_FETCH_MISALIGN_EN
        check("mis_fault", {31'h0, fetch_fault}, 32'h1);
        check("mis_req",   {31'h0, imem_req},    32'h0);
        check("mis_irv",   {31'h0, ir_valid},    32'h1);
        check("mis_ir",    IR,                   32'h0000_0013);
        check("mis_pc",    pc_o,                 32'h0000_0102);
        drive(0, 0, 32'h0, 0, 0, 32'h0);
        @(negedge clk);
        check("mis_hold_fault", {31'h0, fetch_fault}, 32'h1);
        check("mis_hold_irv",   {31'h0, ir_valid},    32'h1);
        check("mis_hold_req",   {31'h0, imem_req},    32'h0);
        drive(0, 0, 32'h0, 0, 1, 32'h0000_0200);
        @(negedge clk);
        check("mis_clr_fault", {31'h0, fetch_fault}, 32'h0);
        check("mis_clr_req",   {31'h0, imem_req},    32'h1);
        check("mis_clr_addr",  imem_addr,            32'h0000_0200);
        check("mis_clr_irv",   {31'h0, ir_valid},    32'h0);
`else
        check("mis_fault", {31'h0, fetch_fault}, 32'h0);
        check("mis_req",   {31'h0, imem_req},    32'h1);
        check("mis_addr",  imem_addr,            32'h0000_0100);
        check("mis_irv",   {31'h0, ir_valid},    32'h0);
        drive(1, 0, 32'h0, 0, 0, 32'h0);
        @(negedge clk);
        drive(0, 1, 32'h1111_1111, 0, 0, 32'h0);
        @(negedge clk);
        drive(0, 0, 32'h0, 1, 0, 32'h0);
        check("mis_irv2",  {31'h0, ir_valid}, 32'h1);
        check("mis_ir2",   IR,                32'h1111_1111);
        check("mis_pc2",   pc_o,              32'h0000_0100);
        check("mis_addr2", imem_addr,         32'h0000_0104);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
